// File: rtl/fft_pkg.sv
// fft_pkg: constants and enums shared by the butterfly front-end blocks.
//   OPERAND_W      - operand width in bits (two's complement)
//   NUM_OPS        - operands per butterfly transaction
//   op_idx_t       - operand slot order as loaded from the switch bank
//   loader_state_t - operand_loader control states
package fft_pkg;

    localparam int OPERAND_W = 8;
    localparam int NUM_OPS   = 6;

    typedef enum logic [2:0] {
        OP_AR = 3'd0,
        OP_AI = 3'd1,
        OP_BR = 3'd2,
        OP_BI = 3'd3,
        OP_WR = 3'd4,
        OP_WI = 3'd5
    } op_idx_t;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } loader_state_t;

endpackage

// File: rtl/operand_loader.sv
// operand_loader: collects the six signed operands of one radix-2 butterfly
// (A, B, W; re/im) from the switch bank, one per debounced load pulse, then
// offers them as one parallel word on a valid/ready handshake.
//
// Ports
//   clk          - clock, rising edge
//   nReset       - synchronous active-low reset
//   sw_data      - switch value captured on load_pulse
//   load_pulse   - 1-clock pulse: store sw_data in slot op_index
//   clear_pulse  - 1-clock pulse: abort entry, zero all operands
//   out_ready    - sink accepts the operand set
//   out_valid    - operand set complete and stable
//   a_re..w_im   - operand registers
//   op_index     - next slot to load (0..5), for the display
//   busy         - entry in progress (some operands loaded, not yet full)
//
// All outputs come straight from flops; no input reaches an output
// combinationally.
module operand_loader
    import fft_pkg::loader_state_t;
    import fft_pkg::COLLECT;
    import fft_pkg::FULL;
    import fft_pkg::OP_WI;
#(
    parameter int W       = fft_pkg::OPERAND_W,
    parameter int NUM_OPS = fft_pkg::NUM_OPS
) (
    input  logic         clk,
    input  logic         nReset,
    input  logic [W-1:0] sw_data,
    input  logic         load_pulse,
    input  logic         clear_pulse,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] a_re,
    output logic [W-1:0] a_im,
    output logic [W-1:0] b_re,
    output logic [W-1:0] b_im,
    output logic [W-1:0] w_re,
    output logic [W-1:0] w_im,
    output logic [2:0]   op_index,
    output logic         busy
);

    loader_state_t state_q, state_d;
    logic [2:0]    op_index_q, op_index_d;
    logic          busy_q, busy_d;
    logic [W-1:0]  ops_q [NUM_OPS];
    logic [W-1:0]  ops_d [NUM_OPS];

    always_comb begin
        state_d    = state_q;
        op_index_d = op_index_q;
        for (int i = 0; i < NUM_OPS; i++) ops_d[i] = ops_q[i];

        case (state_q)
            COLLECT: begin
                if (clear_pulse) begin
                    // Clear beats a simultaneous load.
                    for (int i = 0; i < NUM_OPS; i++) ops_d[i] = '0;
                    op_index_d = '0;
                end else if (op_index_q > 3'(OP_WI)) begin
                    // 6/7 are unreachable; recover without storing anything.
                    op_index_d = '0;
                end else if (load_pulse) begin
                    for (int i = 0; i < NUM_OPS; i++)
                        if (op_index_q == 3'(i)) ops_d[i] = sw_data;
                    if (op_index_q == 3'(OP_WI)) begin
                        op_index_d = '0;
                        state_d    = FULL;
                    end else begin
                        op_index_d = op_index_q + 3'd1;
                    end
                end
            end
            FULL: begin
                // Loads are ignored while the set is on offer. A clear in the
                // same cycle as ready still lets the transfer stand: the sink
                // has already sampled the operands.
                op_index_d = '0;
                if (clear_pulse) begin
                    for (int i = 0; i < NUM_OPS; i++) ops_d[i] = '0;
                    state_d = COLLECT;
                end else if (out_ready) begin
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d    = COLLECT;
                op_index_d = '0;
            end
        endcase

        busy_d = (state_d == COLLECT) && (op_index_d != 3'd0);
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state_q    <= COLLECT;
            op_index_q <= '0;
            busy_q     <= 1'b0;
            for (int i = 0; i < NUM_OPS; i++) ops_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            op_index_q <= op_index_d;
            busy_q     <= busy_d;
            for (int i = 0; i < NUM_OPS; i++) ops_q[i] <= ops_d[i];
        end
    end

    assign out_valid = (state_q == FULL);
    assign op_index  = op_index_q;
    assign busy      = busy_q;
    assign a_re      = ops_q[0];
    assign a_im      = ops_q[1];
    assign b_re      = ops_q[2];
    assign b_im      = ops_q[3];
    assign w_re      = ops_q[4];
    assign w_im      = ops_q[5];

endmodule

// File: doc/operand_loader.md
# operand_loader

Collects the six signed operands of one radix-2 butterfly (A, B, twiddle W; real and imaginary parts) from the board's switch bank, one operand per debounced button press. Sits directly downstream of the debouncers: their 1-clock `pulse` outputs drive `load_pulse` and `clear_pulse`. Once all six operands are captured, the block presents them as one parallel word on a valid/ready handshake to the butterfly datapath.

## Interface
- `W`, default 8: operand width, two's complement.
- `NUM_OPS`, default 6: operands per transaction. Fixed at 6; any other value is out of scope.
- `clk` input 1: single clock; all logic on the rising edge.
- `nReset` input 1: reset, synchronous, active-low.
- `sw_data` input W: switch-bank value, sampled on `load_pulse`.
- `load_pulse` input 1: 1-clock pulse; capture `sw_data` as the current operand.
- `clear_pulse` input 1: 1-clock pulse; abort entry and zero all operands.
- `out_ready` input 1: the butterfly accepts the operand set.
- `out_valid` output 1: the operand set is complete and stable.
- `a_re`, `a_im`, `b_re`, `b_im`, `w_re`, `w_im` output W each: operand registers.
- `op_index` output 3: index of the next operand to load (0..5), for the display.
- `busy` output 1: high when at least one operand has been loaded and `out_valid` is low.

## Operation
- Two states, COLLECT and FULL.
- Operand order by index: 0 → `a_re`, 1 → `a_im`, 2 → `b_re`, 3 → `b_im`, 4 → `w_re`, 5 → `w_im`.
- COLLECT, `load_pulse`=1, `clear_pulse`=0:
  - Register[`op_index`] ← `sw_data`.
  - If `op_index`=5: `op_index` ← 0 and state ← FULL.
  - Otherwise `op_index` increments by 1.
- COLLECT, `clear_pulse`=1: all six registers ← 0 and `op_index` ← 0. Clear wins over a simultaneous load.
- FULL:
  - `out_valid`=1. All operand registers hold their values.
  - `load_pulse` is ignored and `op_index` stays 0.
- FULL, `out_ready`=1: the transfer completes and state ← COLLECT. Registers keep their values for display until overwritten.
- FULL, `clear_pulse`=1, `out_ready`=0: registers ← 0, state ← COLLECT, and no transfer occurs.
- FULL, `clear_pulse`=1 and `out_ready`=1 in the same cycle: the transfer counts (the sink already sampled the data), then registers ← 0 and state ← COLLECT.
- Arithmetic: `op_index` is a 3-bit counter whose only legal values are 0..5. It wraps explicitly from 5 to 0. Values 6 and 7 are unreachable; if one occurs, it is forced to 0 on the next edge.
- Reset (`nReset`=0 at a rising edge): state COLLECT, `op_index`=0, all operand registers 0, `out_valid`=0, `busy`=0. A reset mid-entry or during FULL discards everything.

## Timing
- All outputs are registered. There are no combinational paths from any input to any output.
- A `load_pulse` in cycle t updates the register and `op_index` visibly in cycle t+1.
- The 6th load in cycle t gives `out_valid`=1 from cycle t+1.
- `out_valid` stays high until the first cycle with `out_ready`=1 (or `clear_pulse`=1). It drops in the following cycle.
- Operands are stable for every cycle in which `out_valid`=1.
- After a handshake, the earliest accepted next load is in the cycle after `out_valid` falls. Minimum cycle count for one transaction: 6 loads, then 1 FULL cycle.
- `busy` = (state==COLLECT) && (`op_index`≠0), registered alongside state.

## Structure
- Shared package `fft_pkg` holds:
  - `OPERAND_W` (=8) and `NUM_OPS` (=6).
  - Enum `op_idx_t` {OP_AR, OP_AI, OP_BR, OP_BI, OP_WR, OP_WI}.
  - Enum `loader_state_t` {COLLECT, FULL}.
- No sub-module. The debouncers are instantiated by the top level, not inside this block.

## Test plan
- **Reset:** hold `nReset`=0 for 2 cycles with `load_pulse`=1 → all outputs 0 and `op_index`=0.
- **Full entry:** load 0x05, 0xFB, 0x10, 0x80, 0x7F, 0x00 on six separate pulses, `out_ready`=0.
  - After each pulse, `op_index` steps 1,2,3,4,5,0.
  - `out_valid`=1 one cycle after the 6th pulse, with `a_re`=5, `a_im`=−5, `b_re`=16, `b_im`=−128, `w_re`=127, `w_im`=0.
- **Backpressure:** hold `out_ready`=0 for 20 cycles while pulsing `load_pulse` with `sw_data`=0xAA.
  - Operands and `op_index` stay unchanged.
  - Then assert `out_ready` for 1 cycle → `out_valid` falls next cycle.
- **Clear mid-entry:** after 3 loads, pulse `clear_pulse` and `load_pulse` together → all registers 0, `op_index`=0, `busy`=0.
- **Clear with handshake:** in FULL, assert `out_ready`=1 and `clear_pulse`=1 in the same cycle → the transfer is counted by the bench, then registers are 0 and state is COLLECT.
- **Reset mid-transaction:** after 4 loads, pulse `nReset`=0 for 1 cycle → state fully initial. A subsequent 6 loads complete normally.
